// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter and write sequencer in front of one shared W-bit register.
// Supports bounded lock bursts; all outputs are registered.
module reg_share_arbiter #(
    parameter int N        = 4,
    parameter int W        = 4,
    parameter int HOLD_MAX = 4,
    localparam int OW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    input  logic [N*W-1:0] wdata,
    output logic [W-1:0]   q,
    output logic           q_valid,
    output logic [N-1:0]   gnt,
    output logic [OW-1:0]  owner
);

    localparam int HCW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);
    localparam logic [OW-1:0]  LAST_IDX  = OW'(N - 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    q_reg, q_next;
    logic            q_valid_reg, q_valid_next;
    logic [N-1:0]    gnt_reg, gnt_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic [OW-1:0]   ptr_reg, ptr_next;
    logic [HCW-1:0]  hold_cnt_reg, hold_cnt_next;

    logic [W-1:0]    wdata_arr [N];
    logic [N-1:0]    at_or_above_ptr;
    logic [N-1:0]    masked_req;
    logic [N-1:0]    pick;
    logic [OW-1:0]   win_idx;
    logic [N-1:0]    win_onehot;
    logic [OW-1:0]   ptr_after_win;
    logic            hold_ok;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign wdata_arr[gi]       = wdata[gi*W +: W];
            assign at_or_above_ptr[gi] = (int'(ptr_reg) <= gi);
        end
    endgenerate

    // Requests at or above ptr take precedence; if none, wrap to the lowest index.
    assign masked_req = req & at_or_above_ptr;
    assign pick       = (|masked_req) ? masked_req : req;

    always_comb begin
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick[i]) begin
                win_idx = OW'(i);
            end
        end
    end

    assign win_onehot    = {{(N-1){1'b0}}, 1'b1} << win_idx;
    assign ptr_after_win = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

    assign hold_ok = (state_reg == OWNED) && req[owner_reg] && lock[owner_reg]
                     && (hold_cnt_reg < HOLD_LAST);

    always_comb begin
        state_next    = state_reg;
        q_next        = q_reg;
        q_valid_next  = q_valid_reg;
        gnt_next      = gnt_reg;
        owner_next    = owner_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;

        if (clr) begin
            q_next        = '0;
            q_valid_next  = 1'b0;
            gnt_next      = '0;
            hold_cnt_next = '0;
            state_next    = IDLE;
        end else if (hold_ok) begin
            q_next        = wdata_arr[owner_reg];
            hold_cnt_next = hold_cnt_reg + 1'b1;
            state_next    = OWNED;
        end else if (|req) begin
            q_next        = wdata_arr[win_idx];
            q_valid_next  = 1'b1;
            gnt_next      = win_onehot;
            owner_next    = win_idx;
            ptr_next      = ptr_after_win;
            hold_cnt_next = '0;
            state_next    = lock[win_idx] ? OWNED : IDLE;
        end else begin
            gnt_next      = '0;
            hold_cnt_next = '0;
            state_next    = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            q_reg        <= '0;
            q_valid_reg  <= 1'b0;
            gnt_reg      <= '0;
            owner_reg    <= '0;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            q_reg        <= q_next;
            q_valid_reg  <= q_valid_next;
            gnt_reg      <= gnt_next;
            owner_reg    <= owner_next;
            ptr_reg      <= ptr_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign q       = q_reg;
    assign q_valid = q_valid_reg;
    assign gnt     = gnt_reg;
    assign owner   = owner_reg;

endmodule
